pkt_slot_scheduler: RTL and testbench
=====================================

Name: pkt_slot_scheduler

Overview:
- Round-robin scheduler that shares one rate-limited packet slot among NUM_REQ requesters.
- Issues one packet start per slot and tracks the downstream packet-end.
- Pads early packets so consecutive starts are exactly SPEC cycles apart.
- Flags late and timed-out packets.
- Sits in front of the packet engine and drives its start input; statistics counters feed the timing-verification harness.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
SPEC, 50, slot length in cycles, start-to-start; must be >= 3
TIMEOUT, 200, pkt_time value at which an ACTIVE packet with no end is aborted; must be > SPEC
TW, 16, width of pkt_time/pad counters; 2^TW > TIMEOUT

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
enable  in  1  1 = new grants allowed; 0 = finish current slot, then stay idle
req  in  NUM_REQ  level request per requester
req_mask  in  NUM_REQ  1 = requester eligible
pkt_end  in  1  downstream packet-end pulse
start_o  out  1  one-cycle packet start
grant  out  NUM_REQ  one-hot owner, held from start_o through end of ACTIVE
grant_id  out  clog2(NUM_REQ)  index of current/last owner
busy  out  1  state != IDLE
start_cnt, valid_cnt, late_cnt, timeout_cnt, stray_cnt  out  32 each  event counters, wrap mod 2^32

Behaviour:
- Reset (rst=0, async): state=IDLE; all counters 0; start_o=0; grant=0; grant_id=NUM_REQ-1 so requester 0 wins first; pkt_time=0; pad=0.
- All outputs registered.
- States: IDLE, ACTIVE, PAD.
- IDLE, when enable=1 and (req & req_mask) != 0:
  - Pick the first eligible index searching upward, with wrap, from grant_id+1.
  - Next cycle: state=ACTIVE, start_o=1 for that single cycle, grant=onehot, grant_id=index, pkt_time=1, start_cnt+1.
  - Latency from sampled request to start_o: 1 cycle.
- ACTIVE, cycle with pkt_end=1 and pkt_time=p:
  - p < SPEC-1: valid_cnt+1, pad=SPEC-2-p, go to PAD.
  - p == SPEC-1: valid_cnt+1, go to IDLE.
  - p > SPEC-1: late_cnt+1, go to IDLE.
- ACTIVE, pkt_end=0: pkt_time+1. If pkt_time == TIMEOUT, timeout_cnt+1 and go to IDLE (abort).
- pkt_end and timeout in the same cycle: pkt_end wins and is classified as late.
- grant clears on leaving ACTIVE; grant_id keeps its value.
- PAD: pad==0 goes to IDLE; otherwise pad-1.
- Resulting timing with a continuous request:
  - Start at cycle 0, end at pkt_time p <= SPEC-1: next start_o at cycle SPEC exactly.
  - Late end at p: next start_o at cycle p+1.
- pkt_end while in IDLE or PAD: stray_cnt+1, otherwise ignored.
- start_o never rises in the same cycle that pkt_end is sampled; a pkt_end coincident with start_o is evaluated as ACTIVE with p=1.
- enable falling mid-slot: current ACTIVE/PAD completes normally, then stays IDLE.
- req/req_mask changes during a slot do not affect the current owner.
- A requester that drops req before selection is skipped.
- Counter wrap: 32'hFFFFFFFF + 1 = 0, no flag.
- Reset asserted mid-operation: immediate return to reset values. start_o/grant must drop asynchronously.
- Invariants:
  - state in {IDLE, ACTIVE, PAD}.
  - pad <= SPEC-3.
  - pkt_time <= TIMEOUT.
  - grant is one-hot or zero, and nonzero iff state == ACTIVE.
  - start_cnt == valid_cnt + late_cnt + timeout_cnt + (state==ACTIVE ? 1 : 0).

Test Plan:
- SPEC=50, req=4'b0001, pkt_end at pkt_time=10 for 20 packets -> start_o every 50 cycles; after 1001 cycles from first start: start_cnt=21, valid_cnt=20, late_cnt=0.
- req=4'b1111, mask all ones, each pkt_end at pkt_time=49 -> grant_id sequence 0,1,2,3,0; starts 50 cycles apart.
- req=4'b1010 -> grant_id 1,3,1,3; set req_mask=4'b0010 mid-run -> only 1 is granted after the current slot.
- pkt_end at pkt_time=60 -> late_cnt=1, next start_o 61 cycles after the previous one.
- No pkt_end with TIMEOUT=200 -> timeout_cnt=1 at pkt_time=200, then IDLE; pkt_end in PAD -> stray_cnt+1.
- rst=0 asynchronously during PAD -> outputs and counters 0 immediately. enable=0 mid-ACTIVE -> slot completes, busy=0, no further start_o.

Source files
------------

// File: rtl/pkt_slot_scheduler_if.sv
// ---------------------------------------------------------------------------
// pkt_slot_scheduler_if
//
// Purpose: bundles the request, control and status signals of the packet
// slot scheduler so the scheduler and its environment connect through one
// port.
//
// Signals:
//   enable       1 = new grants allowed
//   req          level request per requester
//   req_mask     1 = requester eligible
//   pkt_end      downstream packet-end pulse
//   start_o      one-cycle packet start
//   grant        one-hot owner while a packet is active
//   grant_id     index of the current/last owner
//   busy         scheduler not idle
//   *_cnt        32-bit event counters (wrap silently)
//
// Modports:
//   master  environment side: drives requests/control, observes status
//   slave   scheduler side: observes requests/control, drives status
// ---------------------------------------------------------------------------
interface pkt_slot_scheduler_if #(
    parameter int unsigned NUM_REQ = 4
);
    localparam int unsigned IdW = $clog2(NUM_REQ);

    logic               enable;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] req_mask;
    logic               pkt_end;

    logic               start_o;
    logic [NUM_REQ-1:0] grant;
    logic [IdW-1:0]     grant_id;
    logic               busy;
    logic [31:0]        start_cnt;
    logic [31:0]        valid_cnt;
    logic [31:0]        late_cnt;
    logic [31:0]        timeout_cnt;
    logic [31:0]        stray_cnt;

    modport master (
        output enable, req, req_mask, pkt_end,
        input  start_o, grant, grant_id, busy,
        input  start_cnt, valid_cnt, late_cnt, timeout_cnt, stray_cnt
    );

    modport slave (
        input  enable, req, req_mask, pkt_end,
        output start_o, grant, grant_id, busy,
        output start_cnt, valid_cnt, late_cnt, timeout_cnt, stray_cnt
    );

endinterface

// File: rtl/pkt_slot_scheduler.sv
// ---------------------------------------------------------------------------
// pkt_slot_scheduler
//
// Purpose: round-robin scheduler sharing one rate-limited packet slot among
// NUM_REQ requesters. One packet start is issued per slot; the downstream
// packet-end is tracked, early packets are padded so consecutive starts are
// exactly SPEC cycles apart, and late / timed-out packets are counted.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   sched_io   scheduler side of pkt_slot_scheduler_if (requests, control,
//              start/grant/status outputs and event counters)
//
// All outputs are registered. Reset drops start_o/grant asynchronously.
// ---------------------------------------------------------------------------
module pkt_slot_scheduler #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned SPEC    = 50,
    parameter int unsigned TIMEOUT = 200,
    parameter int unsigned TW      = 16
) (
    input  logic                clk,
    input  logic                rst,
    pkt_slot_scheduler_if.slave sched_io
);

    localparam int unsigned     IdW      = $clog2(NUM_REQ);
    localparam logic [TW-1:0]   SpecM1   = TW'(SPEC - 1);
    localparam logic [TW-1:0]   SpecM2   = TW'(SPEC - 2);
    localparam logic [TW-1:0]   SpecM3   = TW'(SPEC - 3);
    localparam logic [TW-1:0]   TimeoutV = TW'(TIMEOUT);
    localparam logic [IdW-1:0]  LastId   = IdW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        StIdle,
        StActive,
        StPad
    } state_e;

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_e             state_q, state_d;
    logic               start_q, start_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IdW-1:0]     grant_id_q, grant_id_d;
    logic               busy_q, busy_d;
    logic [TW-1:0]      pkt_time_q, pkt_time_d;
    logic [TW-1:0]      pad_q, pad_d;
    logic [31:0]        start_cnt_q, start_cnt_d;
    logic [31:0]        valid_cnt_q, valid_cnt_d;
    logic [31:0]        late_cnt_q, late_cnt_d;
    logic [31:0]        timeout_cnt_q, timeout_cnt_d;
    logic [31:0]        stray_cnt_q, stray_cnt_d;

    // ------------------------------------------------------------------
    // Round-robin pick: first eligible index at or above grant_id+1,
    // wrapping to the lowest eligible index at or below grant_id.
    // ------------------------------------------------------------------
    logic [NUM_REQ-1:0] eligible;
    logic               pick_found;
    logic [IdW-1:0]     pick_idx;

    assign eligible = sched_io.req & sched_io.req_mask;

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        // Wrap-around candidates first; lowest index wins by overwriting.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (eligible[i] && (i <= int'(grant_id_q))) begin
                pick_found = 1'b1;
                pick_idx   = IdW'(i);
            end
        end
        // Candidates above the last owner take precedence over the wrap.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (eligible[i] && (i > int'(grant_id_q))) begin
                pick_found = 1'b1;
                pick_idx   = IdW'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        start_d       = 1'b0;
        grant_d       = grant_q;
        grant_id_d    = grant_id_q;
        pkt_time_d    = pkt_time_q;
        pad_d         = pad_q;
        start_cnt_d   = start_cnt_q;
        valid_cnt_d   = valid_cnt_q;
        late_cnt_d    = late_cnt_q;
        timeout_cnt_d = timeout_cnt_q;
        stray_cnt_d   = stray_cnt_q;

        // A packet-end with no packet in flight is only counted.
        if (sched_io.pkt_end && (state_q != StActive)) begin
            stray_cnt_d = stray_cnt_q + 32'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (sched_io.enable && pick_found) begin
                    state_d     = StActive;
                    start_d     = 1'b1;
                    grant_d     = {{(NUM_REQ - 1){1'b0}}, 1'b1} << pick_idx;
                    grant_id_d  = pick_idx;
                    pkt_time_d  = TW'(1);
                    start_cnt_d = start_cnt_q + 32'd1;
                end
            end

            StActive: begin
                if (sched_io.pkt_end) begin
                    // pkt_end beats a coincident timeout and lands as late.
                    grant_d    = '0;
                    pkt_time_d = '0;
                    if (pkt_time_q < SpecM1) begin
                        valid_cnt_d = valid_cnt_q + 32'd1;
                        // Pad so the next start lands exactly SPEC cycles
                        // after this one.
                        pad_d       = SpecM2 - pkt_time_q;
                        state_d     = StPad;
                    end else if (pkt_time_q == SpecM1) begin
                        valid_cnt_d = valid_cnt_q + 32'd1;
                        state_d     = StIdle;
                    end else begin
                        late_cnt_d  = late_cnt_q + 32'd1;
                        state_d     = StIdle;
                    end
                end else if (pkt_time_q == TimeoutV) begin
                    timeout_cnt_d = timeout_cnt_q + 32'd1;
                    grant_d       = '0;
                    pkt_time_d    = '0;
                    state_d       = StIdle;
                end else begin
                    pkt_time_d = pkt_time_q + TW'(1);
                end
            end

            StPad: begin
                if (pad_q == '0) begin
                    state_d = StIdle;
                end else begin
                    pad_d = pad_q - TW'(1);
                end
            end

            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            start_q       <= 1'b0;
            grant_q       <= '0;
            // Last owner = NUM_REQ-1 so requester 0 wins the first pick.
            grant_id_q    <= LastId;
            busy_q        <= 1'b0;
            pkt_time_q    <= '0;
            pad_q         <= '0;
            start_cnt_q   <= '0;
            valid_cnt_q   <= '0;
            late_cnt_q    <= '0;
            timeout_cnt_q <= '0;
            stray_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            start_q       <= start_d;
            grant_q       <= grant_d;
            grant_id_q    <= grant_id_d;
            busy_q        <= busy_d;
            pkt_time_q    <= pkt_time_d;
            pad_q         <= pad_d;
            start_cnt_q   <= start_cnt_d;
            valid_cnt_q   <= valid_cnt_d;
            late_cnt_q    <= late_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
            stray_cnt_q   <= stray_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign sched_io.start_o     = start_q;
    assign sched_io.grant       = grant_q;
    assign sched_io.grant_id    = grant_id_q;
    assign sched_io.busy        = busy_q;
    assign sched_io.start_cnt   = start_cnt_q;
    assign sched_io.valid_cnt   = valid_cnt_q;
    assign sched_io.late_cnt    = late_cnt_q;
    assign sched_io.timeout_cnt = timeout_cnt_q;
    assign sched_io.stray_cnt   = stray_cnt_q;

    // ------------------------------------------------------------------
    // Invariants
    // ------------------------------------------------------------------
    grant_onehot0_a: assert property (@(posedge clk) disable iff (!rst)
        $onehot0(grant_q));

    grant_iff_active_a: assert property (@(posedge clk) disable iff (!rst)
        ((grant_q != '0) == (state_q == StActive)));

    pad_bound_a: assert property (@(posedge clk) disable iff (!rst)
        (pad_q <= SpecM3));

    pkt_time_bound_a: assert property (@(posedge clk) disable iff (!rst)
        (pkt_time_q <= TimeoutV));

    cnt_balance_a: assert property (@(posedge clk) disable iff (!rst)
        (start_cnt_q == valid_cnt_q + late_cnt_q + timeout_cnt_q
                        + 32'(state_q == StActive)));

endmodule

// File: tb/tb_pkt_slot_scheduler.sv
// ---------------------------------------------------------------------------
// tb_pkt_slot_scheduler
//
// Self-checking bench for pkt_slot_scheduler (NUM_REQ=4, SPEC=50,
// TIMEOUT=200). Test tasks push the expected owner and start-to-start gap of
// every start they provoke; a monitor pops and compares on each start_o.
// ---------------------------------------------------------------------------
module tb_pkt_slot_scheduler;

    localparam int unsigned NumReq  = 4;
    localparam int unsigned Spec    = 50;
    localparam int unsigned Timeout = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pkt_slot_scheduler_if #(.NUM_REQ(NumReq)) sched ();

    pkt_slot_scheduler #(
        .NUM_REQ (NumReq),
        .SPEC    (Spec),
        .TIMEOUT (Timeout),
        .TW      (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sched_io (sched)
    );

    typedef struct {
        int id;
        int gap; // 0 = gap not checked
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned last_start = 0;

    // Scoreboard: every start_o must match the oldest expectation.
    always @(negedge clk) begin
        exp_t       e;
        logic [3:0] g;
        if (rst === 1'b1 && sched.start_o === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_start: start_o=1 grant_id=%0d at cycle %0d, required no start",
                         sched.grant_id, cyc);
            end else begin
                e = exp_q.pop_front();
                g = 4'b0001 << e.id;
                checks++;
                if (sched.grant_id !== 2'(e.id)) begin
                    errors++;
                    $display("FAIL start_grant_id: got %0d, required %0d", sched.grant_id, e.id);
                end
                checks++;
                if (sched.grant !== g) begin
                    errors++;
                    $display("FAIL start_grant: got %b, required %b", sched.grant, g);
                end
                if (e.gap != 0) begin
                    checks++;
                    if (int'(cyc - last_start) != e.gap) begin
                        errors++;
                        $display("FAIL start_gap: got %0d cycles, required %0d",
                                 int'(cyc - last_start), e.gap);
                    end
                end
            end
            last_start = cyc;
        end
    end

    task automatic push_exp(input int id, input int gap);
        exp_t e;
        e.id  = id;
        e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst            = 1'b0;
        sched.enable   = 1'b0;
        sched.req      = '0;
        sched.req_mask = '1;
        sched.pkt_end  = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drained: %0d expected starts left, required 0", exp_q.size());
            exp_q.delete();
        end
        rst = 1'b1;
    endtask

    // Returns on the negedge where start_o is high.
    task automatic wait_start(input int limit);
        int n = 0;
        while (sched.start_o !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sched.start_o !== 1'b1) begin
            errors++;
            $display("FAIL start_wait: start_o=%b after %0d cycles, required 1", sched.start_o, n);
        end
    endtask

    // Called on the start negedge; pkt_end is sampled when pkt_time == p.
    task automatic end_pkt(input int p);
        repeat (p - 1) @(negedge clk);
        sched.pkt_end = 1'b1;
        @(negedge clk);
        sched.pkt_end = 1'b0;
    endtask

    task automatic wait_idle(input int limit, output int n);
        n = 0;
        while (sched.busy !== 1'b0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sched.busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_wait: busy=%b after %0d cycles, required 0", sched.busy, n);
        end
    endtask

    task automatic test_reset();
        sched.enable   = 1'b0;
        sched.req      = '0;
        sched.req_mask = '1;
        sched.pkt_end  = 1'b0;
        #1 rst = 1'b0;
        #2;
        checks++;
        if (sched.start_o !== 1'b0 || sched.grant !== 4'b0 || sched.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: start_o=%b grant=%b busy=%b, required 0 0000 0",
                     sched.start_o, sched.grant, sched.busy);
        end
        checks++;
        if (sched.grant_id !== 2'd3) begin
            errors++;
            $display("FAIL reset_grant_id: got %0d, required 3", sched.grant_id);
        end
        checks++;
        if ({sched.start_cnt, sched.valid_cnt, sched.late_cnt, sched.timeout_cnt,
             sched.stray_cnt} !== 160'd0) begin
            errors++;
            $display("FAIL reset_counters: got %0d %0d %0d %0d %0d, required all 0",
                     sched.start_cnt, sched.valid_cnt, sched.late_cnt, sched.timeout_cnt,
                     sched.stray_cnt);
        end
        @(negedge clk);
        rst       = 1'b1;
        sched.req = 4'b1111;
        repeat (5) @(negedge clk);
        checks++;
        if (sched.busy !== 1'b0 || sched.start_cnt !== 32'd0) begin
            errors++;
            $display("FAIL disabled_no_grant: busy=%b start_cnt=%0d, required 0 0",
                     sched.busy, sched.start_cnt);
        end
    endtask

    task automatic test_single();
        int n;
        do_reset();
        sched.req    = 4'b0001;
        sched.enable = 1'b1;
        push_exp(0, 0);
        for (int i = 0; i < 20; i++) push_exp(0, Spec);
        for (int i = 0; i < 21; i++) begin
            wait_start(2 * Spec);
            if (i == 20) begin
                checks++;
                if ({sched.start_cnt, sched.valid_cnt, sched.late_cnt} !== {32'd21, 32'd20, 32'd0}) begin
                    errors++;
                    $display("FAIL single_counts: start=%0d valid=%0d late=%0d, required 21 20 0",
                             sched.start_cnt, sched.valid_cnt, sched.late_cnt);
                end
                sched.req = '0;
            end
            end_pkt(10);
        end
        wait_idle(Spec, n);
        checks++;
        if (sched.valid_cnt !== 32'd21 || sched.late_cnt !== 32'd0) begin
            errors++;
            $display("FAIL single_final: valid=%0d late=%0d, required 21 0",
                     sched.valid_cnt, sched.late_cnt);
        end
    endtask

    task automatic test_round_robin();
        int n;
        do_reset();
        sched.req    = 4'b1111;
        sched.enable = 1'b1;
        push_exp(0, 0);
        push_exp(1, Spec);
        push_exp(2, Spec);
        push_exp(3, Spec);
        push_exp(0, Spec);
        for (int i = 0; i < 5; i++) begin
            wait_start(2 * Spec);
            if (i == 4) sched.req = '0;
            end_pkt(49);
        end
        wait_idle(Spec, n);
        checks++;
        if ({sched.start_cnt, sched.valid_cnt, sched.late_cnt} !== {32'd5, 32'd5, 32'd0}) begin
            errors++;
            $display("FAIL rr_counts: start=%0d valid=%0d late=%0d, required 5 5 0",
                     sched.start_cnt, sched.valid_cnt, sched.late_cnt);
        end
    endtask

    task automatic test_mask();
        int n;
        do_reset();
        sched.req    = 4'b1010;
        sched.enable = 1'b1;
        push_exp(1, 0);
        push_exp(3, Spec);
        push_exp(1, Spec);
        push_exp(3, Spec);
        push_exp(1, Spec);
        push_exp(1, Spec);
        for (int i = 0; i < 6; i++) begin
            wait_start(2 * Spec);
            if (i == 3) begin
                sched.req_mask = 4'b0010;
                @(negedge clk);
                checks++;
                if (sched.grant !== 4'b1000 || sched.grant_id !== 2'd3) begin
                    errors++;
                    $display("FAIL mask_owner_held: grant=%b id=%0d, required 1000 3",
                             sched.grant, sched.grant_id);
                end
                end_pkt(48);
            end else begin
                if (i == 5) sched.req = '0;
                end_pkt(49);
            end
        end
        wait_idle(Spec, n);
        checks++;
        if ({sched.start_cnt, sched.valid_cnt} !== {32'd6, 32'd6}) begin
            errors++;
            $display("FAIL mask_counts: start=%0d valid=%0d, required 6 6",
                     sched.start_cnt, sched.valid_cnt);
        end
    endtask

    task automatic test_late();
        int n;
        int ps[4] = '{60, 48, 1, 49};
        do_reset();
        sched.req    = 4'b0001;
        sched.enable = 1'b1;
        push_exp(0, 0);
        push_exp(0, 61);
        push_exp(0, Spec);
        push_exp(0, Spec);
        for (int i = 0; i < 4; i++) begin
            wait_start(2 * Spec);
            if (i == 3) sched.req = '0;
            end_pkt(ps[i]);
        end
        wait_idle(Spec, n);
        checks++;
        if ({sched.start_cnt, sched.valid_cnt, sched.late_cnt} !== {32'd4, 32'd3, 32'd1}) begin
            errors++;
            $display("FAIL late_counts: start=%0d valid=%0d late=%0d, required 4 3 1",
                     sched.start_cnt, sched.valid_cnt, sched.late_cnt);
        end
    endtask

    task automatic test_timeout_stray();
        int n;
        do_reset();
        sched.req    = 4'b0001;
        sched.enable = 1'b1;
        push_exp(0, 0);
        wait_start(10);
        sched.req = '0;
        wait_idle(Timeout + 20, n);
        checks++;
        if (n != 200) begin
            errors++;
            $display("FAIL timeout_time: idle after %0d cycles, required 200", n);
        end
        checks++;
        if ({sched.start_cnt, sched.valid_cnt, sched.late_cnt, sched.timeout_cnt}
                !== {32'd1, 32'd0, 32'd0, 32'd1}) begin
            errors++;
            $display("FAIL timeout_counts: start=%0d valid=%0d late=%0d timeout=%0d, required 1 0 0 1",
                     sched.start_cnt, sched.valid_cnt, sched.late_cnt, sched.timeout_cnt);
        end
        sched.req = 4'b0001;
        push_exp(0, 0);
        wait_start(10);
        sched.req = '0;
        end_pkt(10);
        // Stray end during PAD must not disturb the pad countdown.
        sched.pkt_end = 1'b1;
        @(negedge clk);
        sched.pkt_end = 1'b0;
        wait_idle(Spec, n);
        checks++;
        if (n != 38) begin
            errors++;
            $display("FAIL pad_length: idle after %0d cycles, required 38", n);
        end
        sched.pkt_end = 1'b1;
        @(negedge clk);
        sched.pkt_end = 1'b0;
        @(negedge clk);
        checks++;
        if ({sched.start_cnt, sched.valid_cnt, sched.timeout_cnt, sched.stray_cnt}
                !== {32'd2, 32'd1, 32'd1, 32'd2}) begin
            errors++;
            $display("FAIL stray_counts: start=%0d valid=%0d timeout=%0d stray=%0d, required 2 1 1 2",
                     sched.start_cnt, sched.valid_cnt, sched.timeout_cnt, sched.stray_cnt);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        sched.req    = 4'b0001;
        sched.enable = 1'b1;
        push_exp(0, 0);
        wait_start(10);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (sched.start_o !== 1'b0 || sched.grant !== 4'b0 || sched.busy !== 1'b0
                || sched.start_cnt !== 32'd0) begin
            errors++;
            $display("FAIL async_reset_active: start_o=%b grant=%b busy=%b start_cnt=%0d, required 0 0000 0 0",
                     sched.start_o, sched.grant, sched.busy, sched.start_cnt);
        end
        push_exp(0, 0);
        @(negedge clk);
        rst = 1'b1;
        wait_start(10);
        sched.req = '0;
        end_pkt(10);
        @(negedge clk);
        checks++;
        if (sched.busy !== 1'b1 || sched.valid_cnt !== 32'd1) begin
            errors++;
            $display("FAIL pad_before_reset: busy=%b valid=%0d, required 1 1",
                     sched.busy, sched.valid_cnt);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({sched.start_cnt, sched.valid_cnt} !== 64'd0 || sched.busy !== 1'b0
                || sched.grant_id !== 2'd3) begin
            errors++;
            $display("FAIL async_reset_pad: start=%0d valid=%0d busy=%b id=%0d, required 0 0 0 3",
                     sched.start_cnt, sched.valid_cnt, sched.busy, sched.grant_id);
        end
    endtask

    task automatic test_enable_drop();
        int n;
        do_reset();
        sched.req    = 4'b0001;
        sched.enable = 1'b1;
        push_exp(0, 0);
        wait_start(10);
        repeat (3) @(negedge clk);
        sched.enable = 1'b0;
        end_pkt(7);
        wait_idle(Spec, n);
        checks++;
        if (n != 39) begin
            errors++;
            $display("FAIL enable_slot_complete: idle after %0d cycles, required 39", n);
        end
        repeat (2 * Spec) @(negedge clk);
        checks++;
        if (sched.busy !== 1'b0 || {sched.start_cnt, sched.valid_cnt} !== {32'd1, 32'd1}) begin
            errors++;
            $display("FAIL enable_stays_idle: busy=%b start=%0d valid=%0d, required 0 1 1",
                     sched.busy, sched.start_cnt, sched.valid_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_mask();
        test_late();
        test_timeout_stray();
        test_async_reset();
        test_enable_drop();
        do_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
